// File: rtl/b1_result_collector.sv
// b1_result_collector: tags injected samples through the array latency and buffers the fully
// overlapped convolution outputs in a FWFT FIFO. Optional drop counter: B1_COLLECT_DROP_CNT_EN.
module b1_result_collector #(
   parameter int DATA_W     = 32,
   parameter int TAPS       = 3,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        frame_len,
   input  logic              x_valid,
   input  logic [DATA_W-1:0] y_out,
   output logic [DATA_W-1:0] res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_last,
   output logic              busy,
   output logic              done,
   output logic              overflow
`ifdef B1_COLLECT_DROP_CNT_EN
   ,
   output logic [15:0]       drop_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0]    TAPS_8  = 8'(TAPS);
   localparam logic [7:0]    TAPS_M1 = 8'(TAPS - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         frame_len_q, frame_len_d;
   logic [7:0]         exp_cnt_q, exp_cnt_d;
   logic [7:0]         in_cnt_q, in_cnt_d;
   logic [7:0]         cap_cnt_q, cap_cnt_d;
   logic [LATENCY-1:0] tag_q, tag_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;
   logic [DATA_W:0]    mem_q [FIFO_DEPTH];
   logic [DATA_W:0]    head_s;
   logic               start_acc_s, in_ok_s, entry_s, tag_out_s;
   logic               empty_s, full_s, pop_s, push_s, drop_s, last_s;

   assign start_acc_s = start & (state_q == ST_IDLE);
   assign in_ok_s     = x_valid & (state_q == ST_COLLECT) & (in_cnt_q < frame_len_q);
   assign entry_s     = in_ok_s & (in_cnt_q >= TAPS_M1);
   assign tag_out_s   = tag_q[LATENCY-1];
   assign empty_s     = (count_q == {CW{1'b0}});
   assign full_s      = (count_q == DEPTH_C);
   assign pop_s       = ~empty_s & res_ready;
   // A full buffer still accepts the word when the head leaves on the same edge
   assign push_s      = tag_out_s & (~full_s | pop_s);
   assign drop_s      = tag_out_s & full_s & ~pop_s;
   assign last_s      = (cap_cnt_q == (exp_cnt_q - 8'd1));

   // Frame control: next state, counters and status flags
   always_comb begin
      state_d     = state_q;
      frame_len_d = frame_len_q;
      exp_cnt_d   = exp_cnt_q;
      in_cnt_d    = in_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      overflow_d  = overflow_q | drop_s;
      done_d      = 1'b0;
      tag_d       = tag_q << 1;
      tag_d[0]    = entry_s;
      if (in_ok_s) begin
         in_cnt_d = in_cnt_q + 8'd1;
      end else begin
         in_cnt_d = in_cnt_q;
      end
      if (tag_out_s) begin
         cap_cnt_d = cap_cnt_q + 8'd1;
      end else begin
         cap_cnt_d = cap_cnt_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               frame_len_d = frame_len;
               in_cnt_d    = 8'd0;
               cap_cnt_d   = 8'd0;
               overflow_d  = 1'b0;
               if (frame_len >= TAPS_8) begin
                  exp_cnt_d = frame_len - TAPS_8 + 8'd1;
                  state_d   = ST_COLLECT;
               end else begin
                  exp_cnt_d = 8'd0;
                  state_d   = ST_DRAIN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (cap_cnt_q == exp_cnt_q) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_DRAIN: begin
            if (empty_s) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Result buffer pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
         count_d = count_q + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // State registers; reset discards any frame in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         frame_len_q <= 8'd0;
         exp_cnt_q   <= 8'd0;
         in_cnt_q    <= 8'd0;
         cap_cnt_q   <= 8'd0;
         tag_q       <= {LATENCY{1'b0}};
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_len_q <= frame_len_d;
         exp_cnt_q   <= exp_cnt_d;
         in_cnt_q    <= in_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         tag_q       <= tag_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
      end
   end

   // Buffer storage: {last, data}; contents are masked at the output while empty
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {last_s, y_out};
      end
   end

`ifdef B1_COLLECT_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of words lost to a full buffer
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (start_acc_s) begin
         drop_cnt_d = 16'd0;
      end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Drop counter register
   always_ff @(posedge clk) begin
      if (!rst) begin
         drop_cnt_q <= 16'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   assign head_s    = mem_q[rd_ptr_q];
   assign res_valid = ~empty_s;
   assign res_data  = empty_s ? {DATA_W{1'b0}} : head_s[DATA_W-1:0];
   assign res_last  = ~empty_s & head_s[DATA_W];
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_b1_result_collector.sv
// Bench for b1_result_collector: stub array (y = 10*x after LATENCY cycles), a table of
// frames checked through a result scoreboard, plus reset-mid-frame sequence.
module tb_b1_result_collector;

   localparam int DATA_W  = 32;
   localparam int TAPS    = 3;
   localparam int LATENCY = 4;
   localparam int DEPTH   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        frame_len = 8'd0;
   logic              x_valid = 1'b0;
   logic [31:0]       x_val = 32'd0;
   logic [DATA_W-1:0] y_out;
   logic [DATA_W-1:0] res_data;
   logic              res_valid;
   logic              res_ready = 1'b1;
   logic              res_last;
   logic              busy;
   logic              done;
   logic              overflow;
`ifdef B1_COLLECT_DROP_CNT_EN
   logic [15:0]       drop_cnt;
`endif

   typedef struct {
      int len;
      int gap;
      int stray;
      int rdy_on;
      int kept;
      int ovf;
      int drops;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int ft = 0;
   int rdy_on = 0;
   int done_seen = 0;
   int done_ft = 0;
   int done_cyc = 0;
   int last_pop_cyc = -100;
   logic [DATA_W:0] sb [$];
   logic [DATA_W:0] exp_w;
   logic [31:0] xp [LATENCY] = '{default: 32'd0};
   logic        vp [LATENCY] = '{default: 1'b0};
   vec_t tbl [7];

   always #5 clk = ~clk;

   b1_result_collector #(
      .DATA_W(DATA_W), .TAPS(TAPS), .LATENCY(LATENCY), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .x_valid(x_valid),
      .y_out(y_out), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .res_last(res_last), .busy(busy), .done(done), .overflow(overflow)
`ifdef B1_COLLECT_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   // Stub array: result of a sample appears LATENCY edges later; idle slots carry junk
   always @(posedge clk) begin
      cyc <= cyc + 1;
      xp[0] <= x_valid ? x_val : 32'd0;
      vp[0] <= x_valid;
      for (int i = 1; i < LATENCY; i++) begin
         xp[i] <= xp[i-1];
         vp[i] <= vp[i-1];
      end
   end
   assign y_out = vp[LATENCY-1] ? (xp[LATENCY-1] * 32'd10) : 32'hBAD0_BAD0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Scoreboard: every accepted word must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_word: got %0d, expected no word", res_data);
         end else begin
            exp_w = sb.pop_front();
            chk("res_data", res_data, exp_w[31:0]);
            chk("res_last", 32'(res_last), 32'(exp_w[DATA_W]));
            if (exp_w[DATA_W]) last_pop_cyc = cyc;
         end
      end
   end

   task automatic frame_tick();
      @(posedge clk);
      #1;
      ft++;
      res_ready = (ft >= rdy_on);
      if (done) begin
         done_seen++;
         done_ft  = ft;
         done_cyc = cyc;
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_data"}, res_data, 32'd0);
      chk({tag, "_res_last"}, 32'(res_last), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
`ifdef B1_COLLECT_DROP_CNT_EN
      chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
`endif
   endtask

   task automatic run_frame(input vec_t v);
      int   expn;
      logic lb;
      expn = (v.len >= TAPS) ? (v.len - TAPS + 1) : 0;
      for (int i = 0; i < v.kept; i++) begin
         lb = ((TAPS + i) == v.len);
         sb.push_back({lb, 32'((TAPS + i) * 10)});
      end
      ft = 0;
      rdy_on = v.rdy_on;
      done_seen = 0;
      res_ready = (rdy_on == 0);
      start = 1'b1;
      frame_len = 8'(v.len);
      frame_tick();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("done_after_start", 32'(done), 32'd0);
      for (int i = 1; i <= v.len; i++) begin
         x_val = 32'(i);
         x_valid = 1'b1;
         frame_tick();
         if (v.gap != 0) begin
            x_valid = 1'b0;
            frame_tick();
         end
      end
      x_valid = 1'b0;
      if (v.stray != 0) begin
         repeat (3) begin
            x_val = 32'd99;
            x_valid = 1'b1;
            frame_tick();
            x_valid = 1'b0;
            frame_tick();
         end
      end
      while (done_seen == 0 && ft < 200) begin
         if (ft == rdy_on - 1) begin
            chk("hold_drain_busy", 32'(busy), 32'd1);
            chk("hold_drain_valid", 32'(res_valid), 32'd1);
            chk("hold_drain_head", res_data, 32'd30);
            chk("hold_overflow", 32'(overflow), 32'(v.ovf));
`ifdef B1_COLLECT_DROP_CNT_EN
            chk("hold_drop_cnt", 32'(drop_cnt), 32'(v.drops));
`endif
         end
         frame_tick();
      end
      chk("done_seen", 32'(done_seen), 32'd1);
      if (expn == 0) begin
         chk("short_done_time", 32'(done_ft), 32'd2);
      end else if (v.kept == expn) begin
         chk("done_after_last_pop", 32'(done_cyc - last_pop_cyc), 32'd2);
      end
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("valid_at_done", 32'(res_valid), 32'd0);
      chk("sb_empty_at_done", 32'(sb.size()), 32'd0);
      chk("overflow_at_done", 32'(overflow), 32'(v.ovf));
`ifdef B1_COLLECT_DROP_CNT_EN
      chk("drop_cnt_at_done", 32'(drop_cnt), 32'(v.drops));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        len gap stray rdy_on kept ovf drops
      tbl[0] = '{5, 0, 0, 0,  3, 0, 0};   // nominal
      tbl[1] = '{6, 0, 0, 30, 2, 1, 2};   // backpressure, tail dropped
      tbl[2] = '{2, 0, 0, 0,  0, 0, 0};   // short frame
      tbl[3] = '{5, 1, 1, 0,  3, 0, 0};   // gapped input with stray pulses
      tbl[4] = '{6, 0, 0, 9,  4, 0, 0};   // full buffer popped on a capture edge
      tbl[5] = '{3, 0, 0, 0,  1, 0, 0};   // single valid output
      tbl[6] = '{0, 0, 0, 0,  0, 0, 0};   // empty frame

      repeat (3) @(posedge clk);
      #1;
      chk_reset("por");
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int t = 0; t < 7; t++) begin
         run_frame(tbl[t]);
      end

      // Reset with two results held in the buffer, then a clean frame
      ft = 0;
      rdy_on = 1000;
      res_ready = 1'b0;
      start = 1'b1;
      frame_len = 8'd5;
      frame_tick();
      start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         x_val = 32'(i);
         x_valid = 1'b1;
         frame_tick();
      end
      x_valid = 1'b0;
      repeat (3) frame_tick();
      chk("pre_reset_valid", 32'(res_valid), 32'd1);
      chk("pre_reset_head", res_data, 32'd30);
      rst = 1'b0;
      frame_tick();
      chk_reset("midframe");
      rst = 1'b1;
      run_frame(tbl[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
